// File: rtl/acc_shift_pkg.sv
// Shared definitions for the accumulator shift unit.
// SHIFT_ROTATE_EN: when defined, ROL/ROR are executable shift modes;
// otherwise modes 100/101 are treated as reserved.
package acc_shift_pkg;

  localparam logic [2:0] MODE_LOAD = 3'b000;
  localparam logic [2:0] MODE_SLL  = 3'b001;
  localparam logic [2:0] MODE_SRL  = 3'b010;
  localparam logic [2:0] MODE_SRA  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // True for modes that go through the bit-serial shift path.
  function automatic logic is_shift_mode(input logic [2:0] m);
`ifdef SHIFT_ROTATE_EN
    case (m)
      MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROL, MODE_ROR: return 1'b1;
      default: return 1'b0;
    endcase
`else
    case (m)
      MODE_SLL, MODE_SRL, MODE_SRA: return 1'b1;
      default: return 1'b0;
    endcase
`endif
  endfunction

endpackage

// File: rtl/acc_shift_step.sv
// Combinational single-position shift step for the accumulator datapath.
// SHIFT_ROTATE_EN: when defined, rotate steps are included.
module acc_shift_step
  import acc_shift_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] value,
  input  logic [2:0]   mode,
  input  logic         ls_in,
  input  logic         rs_in,
  output logic [N-1:0] next_value,
  output logic         out_bit
);

  // One-bit shift/rotate of value; unknown modes pass the value through.
  always_comb begin
    next_value = value;
    out_bit    = 1'b0;
    case (mode)
      MODE_SLL: begin
        next_value = {value[N-2:0], ls_in};
        out_bit    = value[N-1];
      end
      MODE_SRL: begin
        next_value = {rs_in, value[N-1:1]};
        out_bit    = value[0];
      end
      MODE_SRA: begin
        next_value = {value[N-1], value[N-1:1]};
        out_bit    = value[0];
      end
`ifdef SHIFT_ROTATE_EN
      MODE_ROL: begin
        next_value = {value[N-2:0], value[N-1]};
        out_bit    = value[N-1];
      end
      MODE_ROR: begin
        next_value = {value[0], value[N-1:1]};
        out_bit    = value[0];
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_shift_seq.sv
// Sequential accumulator shift unit: load plus logical/arithmetic/rotate
// shifts of 0..N positions, one bit per clock, with start/busy/done.
// SHIFT_ROTATE_EN: enables ROL/ROR (otherwise they report err).
module acc_shift_seq
  import acc_shift_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic [AW-1:0] amt,
  input  logic [N-1:0]  din,
  input  logic          ls_in,
  input  logic          rs_in,
  output logic [N-1:0]  dout,
  output logic          busy,
  output logic          done,
  output logic          cout,
  output logic          zero,
  output logic          err
);

  localparam logic [AW-1:0] AMT_MAX = AW'(N);

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic [2:0]    op_mode, op_mode_nxt;
  logic          op_ls, op_ls_nxt;
  logic          op_rs, op_rs_nxt;
  logic [N-1:0]  dout_nxt;
  logic          cout_nxt;
  logic          err_nxt;
  logic [AW-1:0] amt_clamped;
  logic          accept;
  logic [N-1:0]  step_value;
  logic          step_out;

  assign amt_clamped = (amt > AMT_MAX) ? AMT_MAX : amt;
  assign accept      = start && (state != SHIFT);
  assign busy        = (state == SHIFT);
  assign done        = (state == DONE);

  acc_shift_step #(.N(N)) u_step (
    .value      (dout),
    .mode       (op_mode),
    .ls_in      (op_ls),
    .rs_in      (op_rs),
    .next_value (step_value),
    .out_bit    (step_out)
  );

  // Next-state and datapath selection; an accept overrides the DONE->IDLE step.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    op_mode_nxt = op_mode;
    op_ls_nxt   = op_ls;
    op_rs_nxt   = op_rs;
    dout_nxt    = dout;
    cout_nxt    = cout;
    err_nxt     = err;
    case (state)
      SHIFT: begin
        dout_nxt = step_value;
        cout_nxt = step_out;
        cnt_nxt  = cnt - AW'(1);
        if (cnt == AW'(1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: ;
    endcase
    if (accept) begin
      op_mode_nxt = mode;
      op_ls_nxt   = ls_in;
      op_rs_nxt   = rs_in;
      cnt_nxt     = amt_clamped;
      state_nxt   = DONE;
      if (mode == MODE_LOAD) begin
        dout_nxt = din;
        err_nxt  = 1'b0;
      end else if (is_shift_mode(mode)) begin
        err_nxt = 1'b0;
        if (amt_clamped != '0) state_nxt = SHIFT;
      end else begin
        err_nxt = 1'b1;
      end
    end
  end

  // State and datapath registers; zero is derived from the value being stored.
  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      cnt     <= '0;
      op_mode <= MODE_LOAD;
      op_ls   <= 1'b0;
      op_rs   <= 1'b0;
      dout    <= '0;
      cout    <= 1'b0;
      zero    <= 1'b1;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      op_mode <= op_mode_nxt;
      op_ls   <= op_ls_nxt;
      op_rs   <= op_rs_nxt;
      dout    <= dout_nxt;
      cout    <= cout_nxt;
      zero    <= (dout_nxt == '0);
      err     <= err_nxt;
    end
  end

endmodule

// File: doc/acc_shift_seq.md
# acc_shift_seq

Parametrised sequential shift unit for the accumulator datapath, the next generation of the 8-bit load/store shift register. Holds the accumulator value and performs load, logical, arithmetic and rotate shifts of 0..N positions, one bit per clock, under a start/busy/done handshake. Reports the last bit shifted out and a zero flag for the control unit's status logic.

## Interface
- N, 8, data width (≥ 2)
- AW, 4, shift-amount width; must satisfy 2^AW > N
- clk  in  1  rising-edge clock
- clr  in  1  synchronous reset, active-high, highest priority
- start  in  1  request; accepted only when busy=0
- mode  in  3  operation: 000 LOAD, 001 SLL, 010 SRL, 011 SRA, 100 ROL, 101 ROR, 110/111 reserved
- amt  in  AW  shift count; values > N clamp to N
- din  in  N  parallel load data (LOAD only)
- ls_in  in  1  fill bit for SLL
- rs_in  in  1  fill bit for SRL
- dout  out  N  accumulator value
- busy  out  1  shifting in progress
- done  out  1  one-cycle completion pulse
- cout  out  1  last bit shifted out
- zero  out  1  dout == 0
- err  out  1  reserved mode executed; valid with done

## Operation
- States: IDLE, SHIFT, DONE. Reset → IDLE.
- Reset values: dout=0, busy=0, done=0, cout=0, zero=1, err=0, state IDLE.
- Accept: start=1 while in IDLE or DONE captures mode, clamped amt, ls_in, rs_in. din sampled only for LOAD.
- LOAD: dout←din at accept edge → DONE; cout unchanged.
- Shift modes, count k: k=0 → DONE, dout/cout unchanged. k>0 → SHIFT with counter=k.
- Per SHIFT edge (operand is current dout):
  - SLL: shift left, bit0←ls_in, cout←old MSB.
  - SRL: shift right, MSB←rs_in, cout←old bit0.
  - SRA: shift right, MSB retained, cout←old bit0.
  - ROL: MSB wraps to bit0, cout←old MSB.
  - ROR: bit0 wraps to MSB, cout←old bit0.
  - Counter decrements; on reaching 0 → DONE.
- Reserved mode: dout/cout unchanged, err=1, → DONE.
- DONE: done=1 for exactly one cycle, then IDLE unless a new start is accepted.
- err cleared on every accept of a non-reserved mode.
- zero is registered and always tracks the registered dout.
- start while busy=1 is ignored; inputs are not re-sampled.
- clr at any time, including mid-shift, forces the reset values on the next edge and abandons the operation.

## Timing
- Accept edge E0. LOAD, k=0 or reserved: done high in the cycle after E0 (1-cycle latency).
- Shift with k>0: busy high from E0 through Ek; done high after Ek; latency k+1 cycles.
- dout updates once per SHIFT edge; intermediate values are visible.
- Back-to-back: start asserted during the done cycle is accepted with no bubble.

## Configuration
- SHIFT_ROTATE_EN defined: ROL/ROR as specified.
- Undefined: modes 100/101 behave as reserved (err=1, no change, 1-cycle done); rotate muxing removed.

## Structure
- Package acc_shift_pkg: mode encodings (MODE_LOAD…MODE_ROR), state enum (IDLE, SHIFT, DONE).
- Sub-module acc_shift_step: combinational single-bit step (value, mode, fill bits) → (next value, out bit), instantiated once in the datapath.

## Test plan
- clr; LOAD din=8'hA5 → dout=A5 one cycle after start, done one pulse, cout=0, zero=0.
- After the LOAD above: SLL amt=3, ls_in=1 → busy 3 cycles, dout=8'h2F, cout=1, done at latency 4.
- LOAD 8'h84; SRA amt=2 → dout=8'hE1, cout=0. Then SRL amt=9 (clamps to 8), rs_in=0 → dout=00, zero=1, latency 9.
- LOAD 8'h81; ROL amt=1 → dout=8'h03, cout=1. Without SHIFT_ROTATE_EN → dout=81, err=1.
- Reserved mode 110 → err=1, dout unchanged, 1-cycle done. Next SLL amt=0 → err=0, no change.
- start pulse while busy is ignored. clr asserted mid-shift → next cycle dout=0, busy=0, done=0, zero=1.
